// File: rtl/mem_req_arbiter.sv
// Shares one sram-like memory port between the IF and EXE masters, tracks the
// owner of each accepted transaction in an in-order FIFO and routes responses back.
module mem_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [SC_W-1:0]  SC_LIMIT  = SC_W'(STARVE_LIMIT);

    // Owner bit per outstanding transaction: 0 = inst, 1 = data.
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PTR_W-1:0]           head_q;
    logic [PTR_W-1:0]           tail_q;
    logic [CNT_W-1:0]           count_q;
    logic [SC_W-1:0]            starve_cnt_q;

    logic full;
    logic empty;
    logic sel_data;
    logic sel_inst;
    logic push;
    logic pop;
    logic head_owner;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // Data has priority unless inst has watched STARVE_LIMIT data grants go by.
    assign sel_data = data_req && !(inst_req && (starve_cnt_q == SC_LIMIT));
    assign sel_inst = inst_req && !sel_data;

    assign mem_req   = (inst_req || data_req) && !full && resetn;
    assign mem_wr    = sel_data ? data_wr    : inst_wr;
    assign mem_size  = sel_data ? data_size  : inst_size;
    assign mem_addr  = sel_data ? data_addr  : inst_addr;
    assign mem_wstrb = sel_data ? data_wstrb : inst_wstrb;
    assign mem_wdata = sel_data ? data_wdata : inst_wdata;

    assign inst_addr_ok = mem_addr_ok && mem_req && sel_inst;
    assign data_addr_ok = mem_addr_ok && mem_req && sel_data;

    assign push       = mem_req && mem_addr_ok;
    // A response with nothing outstanding (spurious or pre-reset) is dropped.
    assign pop        = mem_data_ok && !empty && resetn;
    assign head_owner = fifo_q[head_q];

    assign inst_data_ok = pop && !head_owner;
    assign data_data_ok = pop && head_owner;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fifo_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[tail_q] <= sel_data;
                tail_q         <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (!inst_req || inst_addr_ok) begin
                starve_cnt_q <= '0;
            end else if (data_addr_ok && (starve_cnt_q != SC_LIMIT)) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus a random
// phase, all checked against a queue-based reference model.
module tb_mem_req_arbiter;

    localparam int MAXO   = 2;
    localparam int STARVE = 3;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    mem_req_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: owners of outstanding transactions in issue order.
    bit owner_q[$];
    int starve_m = 0;

    logic        obs_mem_req, obs_iaok, obs_daok, obs_idok, obs_ddok;
    logic [31:0] obs_addr;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_fields();
        inst_wr    = 1'($urandom_range(0, 1));
        data_wr    = 1'($urandom_range(0, 1));
        inst_size  = 2'($urandom_range(0, 2));
        data_size  = 2'($urandom_range(0, 2));
        inst_addr  = $urandom;
        data_addr  = $urandom;
        inst_wstrb = 4'($urandom_range(0, 15));
        data_wstrb = 4'($urandom_range(0, 15));
        inst_wdata = $urandom;
        data_wdata = $urandom;
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model at the edge.
    task automatic step(input logic rn, input logic ir, input logic dr,
                        input logic aok, input logic dok, input logic [31:0] rd);
        logic sd, si, emr, eia, eda, epop, eid, edd;
        logic [70:0] exp_fields;
        resetn = rn; inst_req = ir; data_req = dr;
        mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
        #1;
        sd   = dr && !(ir && starve_m == STARVE);
        si   = ir && !sd;
        emr  = rn && (ir || dr) && (owner_q.size() < MAXO);
        eia  = aok && emr && si;
        eda  = aok && emr && sd;
        epop = rn && dok && (owner_q.size() > 0);
        eid  = epop && (owner_q[0] == 1'b0);
        edd  = epop && (owner_q[0] == 1'b1);
        exp_fields = sd ? {data_wr, data_size, data_addr, data_wstrb, data_wdata}
                        : {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};

        obs_mem_req = mem_req; obs_iaok = inst_addr_ok; obs_daok = data_addr_ok;
        obs_idok = inst_data_ok; obs_ddok = data_data_ok; obs_addr = mem_addr;

        check("handshake {req,iaok,daok,idok,ddok}",
              128'({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}),
              128'({emr, eia, eda, eid, edd}));
        if (emr)
            check("mem fields", 128'({mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata}),
                  128'(exp_fields));
        check("rdata", 128'({inst_rdata, data_rdata}), 128'({rd, rd}));

        @(posedge clk);
        if (!rn) begin
            owner_q.delete();
            starve_m = 0;
        end else begin
            if (epop) void'(owner_q.pop_front());
            if (eia || eda) owner_q.push_back(eda);
            if (!ir || eia) starve_m = 0;
            else if (eda && starve_m < STARVE) starve_m++;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < MAXO + 2 && owner_q.size() > 0; k++)
            step(1, 0, 0, 0, 1, $urandom);
    endtask

    initial begin
        logic [1:0] exp_seq [8];
        int         grants;
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
        resetn = 1'b1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        mem_rdata = '0;
        rand_fields();
        @(negedge clk);

        // Reset holds every handshake output low
        step(0, 1, 1, 1, 1, 32'hDEAD_BEEF);
        check("reset mem_req", 128'(obs_mem_req), 128'(0));
        check("reset oks", 128'({obs_iaok, obs_daok, obs_idok, obs_ddok}), 128'(0));
        step(1, 0, 0, 0, 0, '0);

        // Data priority
        data_addr = 32'h1000_0040;
        step(1, 1, 1, 1, 0, '0);
        check("prio mem_addr", 128'(obs_addr), 128'(32'h1000_0040));
        check("prio oks {i,d}", 128'({obs_iaok, obs_daok}), 128'(2'b01));
        step(1, 0, 0, 0, 1, 32'h5555_AAAA);
        check("prio owner is data", 128'({obs_idok, obs_ddok}), 128'(2'b01));

        // In-order routing
        inst_addr = 32'hBFC0_0000;
        step(1, 1, 0, 1, 0, '0);
        data_addr = 32'h8000_0010;
        step(1, 0, 1, 1, 0, '0);
        step(1, 0, 0, 0, 1, 32'h1111_1111);
        check("order first inst", 128'({obs_idok, obs_ddok}), 128'(2'b10));
        step(1, 0, 0, 0, 1, 32'h2222_2222);
        check("order second data", 128'({obs_idok, obs_ddok}), 128'(2'b01));

        // Full stall and release one cycle after the pop
        step(1, 1, 1, 1, 0, '0);
        step(1, 1, 1, 1, 0, '0);
        step(1, 1, 1, 1, 0, '0);
        check("full stall mem_req", 128'(obs_mem_req), 128'(0));
        step(1, 1, 1, 1, 1, 32'h3333_3333);
        check("full pop-cycle mem_req", 128'(obs_mem_req), 128'(0));
        step(1, 1, 1, 0, 0, '0);
        check("after pop mem_req", 128'(obs_mem_req), 128'(1));
        drain();

        // Starvation: D D D I D D D I
        step(0, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, 1, 1, $urandom);
            check($sformatf("starve grant %0d", i), 128'({obs_iaok, obs_daok}), 128'(exp_seq[i]));
        end
        drain();

        // Spurious response and reset-aborted transaction
        step(1, 0, 0, 0, 1, 32'h4444_4444);
        check("spurious dropped", 128'({obs_idok, obs_ddok}), 128'(0));
        step(1, 1, 0, 1, 0, '0);
        step(0, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 1, 32'h6666_6666);
        check("post-reset resp dropped", 128'({obs_idok, obs_ddok}), 128'(0));
        grants = 0;
        for (int i = 0; i < MAXO + 1; i++) begin
            step(1, 1, 0, 1, 0, '0);
            if (obs_iaok) grants++;
        end
        check("fifo empty after abort", 128'(grants), 128'(MAXO));
        drain();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_fields();
            step(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
